// File: rtl/datamem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : datamem_arbiter
// Purpose  : Two-port (CPU / debug-DMA) arbiter in front of a 32x32 DataMem.
//            Define DATAMEM_ARB_ROUND_ROBIN_EN for round-robin conflicts,
//            otherwise port 0 has fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
module datamem_arbiter (
    input  logic        clk,
    input  logic        rst,

    input  logic        req0,
    input  logic        we0,
    input  logic [4:0]  addr0,
    input  logic [31:0] wdata0,
    output logic        ack0,
    output logic [31:0] rdata0,

    input  logic        req1,
    input  logic        we1,
    input  logic [4:0]  addr1,
    input  logic [31:0] wdata1,
    output logic        ack1,
    output logic [31:0] rdata1,

    output logic [4:0]  mem_A,
    output logic [31:0] mem_WD,
    output logic        mem_WE,
    input  logic [31:0] mem_RD,

    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [4:0]  r_addr;
    logic [31:0] r_wdata;
    logic        r_we;
    logic        r_port;
    logic [31:0] r_data;
    logic [31:0] r_rdata0;
    logic [31:0] r_rdata1;
    logic        r_last_grant;

    logic        w_any_req;
    logic        w_winner;
    logic        w_latch;
    logic        w_capture;
    logic        w_done0;
    logic        w_done1;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    always_comb begin
        w_any_req = req0 | req1;
        w_winner  = 1'b0;
`ifdef DATAMEM_ARB_ROUND_ROBIN_EN
        if (req0 && req1) begin
            w_winner = ~r_last_grant;
        end else begin
            w_winner = req1;
        end
`else
        w_winner = ~req0 & req1;
`endif
    end

`ifndef DATAMEM_ARB_ROUND_ROBIN_EN
    // History is kept for observability only in the fixed-priority build.
    logic w_unused_last_grant;
    assign w_unused_last_grant = r_last_grant;
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_latch     = 1'b1;
                    w_state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                w_capture   = 1'b1;
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Request latch: inputs are ignored once a grant has been taken
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr       <= 5'd0;
            r_wdata      <= 32'd0;
            r_we         <= 1'b0;
            r_port       <= 1'b0;
            r_last_grant <= 1'b1;
        end else if (w_latch) begin
            r_addr       <= w_winner ? addr1  : addr0;
            r_wdata      <= w_winner ? wdata1 : wdata0;
            r_we         <= w_winner ? we1    : we0;
            r_port       <= w_winner;
            r_last_grant <= w_winner;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= 32'd0;
        end else if (w_capture) begin
            r_data <= mem_RD;
        end
    end

    // ------------------------------------------------------------------
    // Completion: held read data per port
    // ------------------------------------------------------------------
    assign w_done0 = (r_state == ST_DONE) && !r_port;
    assign w_done1 = (r_state == ST_DONE) &&  r_port;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata0 <= 32'd0;
            r_rdata1 <= 32'd0;
        end else begin
            if (w_done0 && !r_we) begin
                r_rdata0 <= r_data;
            end
            if (w_done1 && !r_we) begin
                r_rdata1 <= r_data;
            end
        end
    end

    // The captured word is forwarded during the ack cycle itself.
    assign rdata0 = (w_done0 && !r_we) ? r_data : r_rdata0;
    assign rdata1 = (w_done1 && !r_we) ? r_data : r_rdata1;
    assign ack0   = w_done0;
    assign ack1   = w_done1;

    // ------------------------------------------------------------------
    // Memory side: write enable is a pure state decode so reset kills it
    // ------------------------------------------------------------------
    assign mem_A  = r_addr;
    assign mem_WD = r_wdata;
    assign mem_WE = (r_state == ST_ACCESS) && r_we;
    assign busy   = (r_state != ST_IDLE);

endmodule
`default_nettype wire
